tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
CP0-side controller for the TLB instructions TLBP, TLBR, TLBWI and TLBWR. It owns the TLB-related CP0 registers: Index, Random, EntryLo0, EntryLo1 and EntryHi. It drives the tlb search port 1, the write port and the read port. It sits between the pipeline's CP0/exception stage and the tlb array, with a valid/ready op handshake and a one-cycle done pulse.

Parameters:
TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM) is the index width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  TLB instruction request
op_type  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR
op_ready  out  1  controller idle, can accept an op
op_done  out  1  one-cycle pulse when the op is complete
mtc0_we  in  1  CP0 register write strobe
mtc0_addr  in  5  CP0 register number
mtc0_wdata  in  32  write data
mfc0_addr  in  5  read register number
mfc0_rdata  out  32  combinational read data
s1_vpn2 / s1_odd_page / s1_asid  out  19/1/8  search request
s1_found / s1_index  in  1/IW  search result
we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  out  tlb write-port widths
r_index  out  IW  read index
r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  in  tlb read-port widths

Behaviour:
- Register formats (MIPS32). All bits not listed read as 0.
  - Index (reg 0): P[31], IDX[IW-1:0].
  - Random (reg 1): [IW-1:0].
  - EntryLo0/1 (reg 2/3): PFN[25:6], C[5:3], D[2], V[1], G[0].
  - EntryHi (reg 10): VPN2[31:13], ASID[7:0].
- Reset values:
  - Index = 0, EntryLo0/1 = 0, EntryHi = 0.
  - Random = TLBNUM-1.
  - FSM = IDLE, op_ready = 1, op_done = 0, we = 0.
- Random behaviour:
  - Decrements every cycle; wraps from 0 to TLBNUM-1.
  - mtc0 writes to Random are ignored.
- mtc0 writes:
  - Accepted in any cycle and take effect at the clock edge.
  - Index.P is not software-writable.
  - Unlisted register numbers are ignored.
  - mfc0_rdata returns 0 for unlisted register numbers.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: op_ready = 1. On op_valid & op_ready, latch op_type and go to EXEC. If mtc0 fires in the same cycle, the new value is the one EXEC uses.
  - EXEC (exactly 1 cycle): drive the ports from the current register values and capture results at the end of the cycle.
  - DONE: op_done = 1 for one cycle, op_ready = 0, then return to IDLE.
  - Op latency: accept edge + 2 cycles; op_done is high in the 2nd cycle after acceptance.
- Search port 1 drive:
  - s1_vpn2 = EntryHi.VPN2, s1_asid = EntryHi.ASID, s1_odd_page = 0.
  - Driven in every state; tlb search is combinational.
- r_index = Index.IDX, driven in every state.
- Op actions in EXEC:
  - TLBP: if s1_found, Index.P = 0 and Index.IDX = s1_index; otherwise Index.P = 1 and IDX is unchanged.
  - TLBR:
    - EntryHi.VPN2 = r_vpn2, EntryHi.ASID = r_asid.
    - EntryLo0 = {r_pfn0, r_c0, r_d0, r_v0, r_g}.
    - EntryLo1 = {r_pfn1, r_c1, r_d1, r_v1, r_g}.
  - TLBWI / TLBWR:
    - we = 1 for exactly the EXEC cycle.
    - w_index = Index.IDX (TLBWI) or the Random value during EXEC (TLBWR).
    - w_vpn2 and w_asid come from EntryHi; w_*0 and w_*1 fields come from EntryLo0/1.
    - w_g = EntryLo0.G & EntryLo1.G.
  - we = 0 in all other cycles.
- Conflict rule: if mtc0 targets a register that the EXEC op also updates in the same cycle, the op result wins.
- op_valid outside IDLE is ignored. The requester holds op_valid until it is accepted.
- resetn asserted mid-op aborts the op immediately (asynchronously): we drops to 0, no done pulse is issued, and all registers take their reset values.

Decomposition:
- Package tlb_pkg:
  - Op encodings: TLB_OP_P, TLB_OP_R, TLB_OP_WI, TLB_OP_WR.
  - CP0 register numbers: CP0_INDEX=0, CP0_RANDOM=1, CP0_ENTRYLO0=2, CP0_ENTRYLO1=3, CP0_ENTRYHI=10.
  - EntryLo/EntryHi field bit positions.
  - FSM state encoding.
- One sub-module: tlb_random_cnt (down-counter with wrap, parameter TLBNUM). Everything else lives in tlb_op_ctrl.

Test Plan:
- Reset with no activity:
  - Random reads 15, 14, 13… on successive cycles; wraps 0 -> 15.
  - All other registers read 0; op_ready = 1.
- TLBWI write:
  - mtc0 Index = 5, EntryHi = 0x0040_2033, EntryLo0 = 0x0000_1057, EntryLo1 = 0x0000_1086; then TLBWI.
  - Required: we = 1 for one cycle with w_index = 5, w_vpn2 = 0x00201, w_asid = 0x33, w_pfn0 = 0x41, w_c0 = 2, w_d0 = 1, w_v0 = 1, w_pfn1 = 0x42, w_v1 = 1, w_g = 0.
  - op_done follows 2 cycles after acceptance.
- TLBP:
  - Search hit with s1_index = 5: Index reads 0x0000_0005.
  - Search miss: Index reads 0x8000_0005 (P = 1, IDX unchanged).
- TLBR with Index = 7 and a tlb model holding entry 7:
  - EntryHi/EntryLo0/EntryLo1 match the entry's fields; G replicated into bit 0 of both EntryLo registers.
- TLBWR: w_index equals the Random value sampled during EXEC, compared against a bench shadow counter.
- Contention:
  - op_valid during EXEC/DONE is ignored (no second we pulse).
  - mtc0 Index = 3 in the same cycle as TLBP's EXEC with a hit at index 9: Index = 9.
  - resetn pulled low during EXEC: we falls immediately and no op_done pulse occurs.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared encodings for the TLB instruction controller: op codes, CP0 register
// numbers, CP0 field positions and FSM states.
package tlb_pkg;

    typedef enum logic [1:0] {
        TLB_OP_P  = 2'd0,
        TLB_OP_R  = 2'd1,
        TLB_OP_WI = 2'd2,
        TLB_OP_WR = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } tlb_state_e;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    // EntryLo is held as its low 26 bits; everything above PFN reads as zero.
    localparam int LO_W       = 26;
    localparam int LO_G       = 0;
    localparam int LO_V       = 1;
    localparam int LO_D       = 2;
    localparam int LO_C_LSB   = 3;
    localparam int LO_C_MSB   = 5;
    localparam int LO_PFN_LSB = 6;
    localparam int LO_PFN_MSB = 25;

    localparam int HI_ASID_MSB = 7;
    localparam int HI_VPN2_LSB = 13;
    localparam int HI_VPN2_MSB = 31;

    localparam int INDEX_P = 31;

endpackage

// File: rtl/tlb_random_cnt.sv
// CP0 Random register: free-running down-counter that wraps from 0 to TLBNUM-1.
module tlb_random_cnt #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [IW-1:0] count_o
);

    logic [IW-1:0] count_q;
    logic [IW-1:0] count_d;

    always_comb begin
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
            count_d = IW'(TLBNUM - 1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= IW'(TLBNUM - 1);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// CP0-side controller for TLBP/TLBR/TLBWI/TLBWR: owns Index, Random, EntryLo0/1
// and EntryHi, and sequences each op through a single EXEC cycle.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,
    input  logic          mtc0_we,
    input  logic [4:0]    mtc0_addr,
    input  logic [31:0]   mtc0_wdata,
    input  logic [4:0]    mfc0_addr,
    output logic [31:0]   mfc0_rdata,
    output logic [18:0]   s1_vpn2,
    output logic          s1_odd_page,
    output logic [7:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic [18:0]   r_vpn2,
    input  logic [7:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_pfn0,
    input  logic [2:0]    r_c0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_pfn1,
    input  logic [2:0]    r_c1,
    input  logic          r_d1,
    input  logic          r_v1
);

    tlb_state_e    state_q, state_d;
    tlb_op_e       op_q, op_d;
    logic          index_p_q, index_p_d;
    logic [IW-1:0] index_idx_q, index_idx_d;
    logic [LO_W-1:0] lo0_q, lo0_d;
    logic [LO_W-1:0] lo1_q, lo1_d;
    logic [18:0]   hi_vpn2_q, hi_vpn2_d;
    logic [7:0]    hi_asid_q, hi_asid_d;
    logic [IW-1:0] random_val;
    logic          unused_wdata;

    assign unused_wdata = ^mtc0_wdata[12:8];

    tlb_random_cnt #(.TLBNUM(TLBNUM)) u_random (
        .clk     (clk),
        .resetn  (resetn),
        .count_o (random_val)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= TLB_OP_P;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // we is decoded from the state register so an async reset drops it at once.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        op_ready = 1'b0;
        op_done  = 1'b0;
        we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    op_d    = tlb_op_e'(op_type);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                we      = (op_q == TLB_OP_WI) || (op_q == TLB_OP_WR);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                op_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Software writes apply first; an EXEC-cycle op result overrides them.
    always_comb begin
        index_p_d   = index_p_q;
        index_idx_d = index_idx_q;
        lo0_d       = lo0_q;
        lo1_d       = lo1_q;
        hi_vpn2_d   = hi_vpn2_q;
        hi_asid_d   = hi_asid_q;
        if (mtc0_we) begin
            case (mtc0_addr)
                CP0_INDEX:    index_idx_d = mtc0_wdata[IW-1:0];
                CP0_ENTRYLO0: lo0_d = mtc0_wdata[LO_W-1:0];
                CP0_ENTRYLO1: lo1_d = mtc0_wdata[LO_W-1:0];
                CP0_ENTRYHI: begin
                    hi_vpn2_d = mtc0_wdata[HI_VPN2_MSB:HI_VPN2_LSB];
                    hi_asid_d = mtc0_wdata[HI_ASID_MSB:0];
                end
                default: ;
            endcase
        end
        if (state_q == ST_EXEC) begin
            case (op_q)
                TLB_OP_P: begin
                    if (s1_found) begin
                        index_p_d   = 1'b0;
                        index_idx_d = s1_index;
                    end else begin
                        index_p_d   = 1'b1;
                        index_idx_d = index_idx_q;
                    end
                end
                TLB_OP_R: begin
                    hi_vpn2_d = r_vpn2;
                    hi_asid_d = r_asid;
                    lo0_d     = {r_pfn0, r_c0, r_d0, r_v0, r_g};
                    lo1_d     = {r_pfn1, r_c1, r_d1, r_v1, r_g};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_p_q   <= 1'b0;
            index_idx_q <= '0;
            lo0_q       <= '0;
            lo1_q       <= '0;
            hi_vpn2_q   <= '0;
            hi_asid_q   <= '0;
        end else begin
            index_p_q   <= index_p_d;
            index_idx_q <= index_idx_d;
            lo0_q       <= lo0_d;
            lo1_q       <= lo1_d;
            hi_vpn2_q   <= hi_vpn2_d;
            hi_asid_q   <= hi_asid_d;
        end
    end

    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            CP0_INDEX: begin
                mfc0_rdata[INDEX_P]  = index_p_q;
                mfc0_rdata[IW-1:0]   = index_idx_q;
            end
            CP0_RANDOM:   mfc0_rdata[IW-1:0] = random_val;
            CP0_ENTRYLO0: mfc0_rdata[LO_W-1:0] = lo0_q;
            CP0_ENTRYLO1: mfc0_rdata[LO_W-1:0] = lo1_q;
            CP0_ENTRYHI: begin
                mfc0_rdata[HI_VPN2_MSB:HI_VPN2_LSB] = hi_vpn2_q;
                mfc0_rdata[HI_ASID_MSB:0]           = hi_asid_q;
            end
            default: ;
        endcase
    end

    assign s1_vpn2     = hi_vpn2_q;
    assign s1_asid     = hi_asid_q;
    assign s1_odd_page = 1'b0;
    assign r_index     = index_idx_q;

    assign w_index = (op_q == TLB_OP_WR) ? random_val : index_idx_q;
    assign w_vpn2  = hi_vpn2_q;
    assign w_asid  = hi_asid_q;
    assign w_g     = lo0_q[LO_G] & lo1_q[LO_G];
    assign w_pfn0  = lo0_q[LO_PFN_MSB:LO_PFN_LSB];
    assign w_c0    = lo0_q[LO_C_MSB:LO_C_LSB];
    assign w_d0    = lo0_q[LO_D];
    assign w_v0    = lo0_q[LO_V];
    assign w_pfn1  = lo1_q[LO_PFN_MSB:LO_PFN_LSB];
    assign w_c1    = lo1_q[LO_C_MSB:LO_C_LSB];
    assign w_d1    = lo1_q[LO_D];
    assign w_v1    = lo1_q[LO_V];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: stimulus queues expected writes, reads and
// done cycles; a negedge monitor pops and compares whenever the DUT presents them.
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 16;
    localparam int IW     = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [18:0]   vpn2;
        logic [7:0]    asid;
        logic          g;
        logic [19:0]   pfn0;
        logic [2:0]    c0;
        logic          d0;
        logic          v0;
        logic [19:0]   pfn1;
        logic [2:0]    c1;
        logic          d1;
        logic          v1;
    } wr_t;

    logic          clk;
    logic          resetn;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready;
    logic          op_done;
    logic          mtc0_we;
    logic [4:0]    mtc0_addr;
    logic [31:0]   mtc0_wdata;
    logic [4:0]    mfc0_addr;
    logic [31:0]   mfc0_rdata;
    logic [18:0]   s1_vpn2;
    logic          s1_odd_page;
    logic [7:0]    s1_asid;
    logic          s1_found;
    logic [IW-1:0] s1_index;
    logic          we;
    logic [IW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0;
    logic [2:0]    w_c0;
    logic          w_d0;
    logic          w_v0;
    logic [19:0]   w_pfn1;
    logic [2:0]    w_c1;
    logic          w_d1;
    logic          w_v1;
    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0;
    logic [2:0]    r_c0;
    logic          r_d0;
    logic          r_v0;
    logic [19:0]   r_pfn1;
    logic [2:0]    r_c1;
    logic          r_d1;
    logic          r_v1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic rdValid;
    logic [IW-1:0] shadowRand;

    wr_t          expWrQ[$];
    logic [31:0]  rdExpQ[$];
    string        rdNameQ[$];
    int           doneQ[$];
    wr_t          monAct;
    wr_t          monExp;

    // Search model: a single programmable entry; read model: entry 7 only.
    logic          hitEn;
    logic [18:0]   hitVpn2;
    logic [7:0]    hitAsid;
    logic [IW-1:0] hitIdx;

    assign s1_found = hitEn && (s1_vpn2 == hitVpn2) && (s1_asid == hitAsid) && !s1_odd_page;
    assign s1_index = hitIdx;

    assign r_vpn2 = (r_index == 4'd7) ? 19'h12345 : '0;
    assign r_asid = (r_index == 4'd7) ? 8'h5a : '0;
    assign r_g    = (r_index == 4'd7);
    assign r_pfn0 = (r_index == 4'd7) ? 20'hABCDE : '0;
    assign r_c0   = (r_index == 4'd7) ? 3'd3 : '0;
    assign r_d0   = (r_index == 4'd7);
    assign r_v0   = 1'b0;
    assign r_pfn1 = (r_index == 4'd7) ? 20'h13579 : '0;
    assign r_c1   = (r_index == 4'd7) ? 3'd5 : '0;
    assign r_d1   = 1'b0;
    assign r_v1   = (r_index == 4'd7);

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready), .op_done(op_done),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) shadowRand <= 4'hF;
        else         shadowRand <= shadowRand - 4'd1;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic wr_t mkWr(input logic [IW-1:0] idx, input logic [18:0] vpn2,
                                 input logic [7:0] asid, input logic g,
                                 input logic [19:0] pfn0, input logic [2:0] c0,
                                 input logic d0, input logic v0,
                                 input logic [19:0] pfn1, input logic [2:0] c1,
                                 input logic d1, input logic v1);
        return {idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    // Monitor: compares every write pulse, done pulse and tagged register read.
    always @(negedge clk) begin
        if (we) begin
            if (expWrQ.size() == 0) begin
                checkOutput("unexpected_we", 1, 0);
            end else begin
                monExp = expWrQ.pop_front();
                monAct = {w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                          w_pfn1, w_c1, w_d1, w_v1};
                checkOutput("write_port", monAct, monExp);
            end
        end
        if (op_done) begin
            if (doneQ.size() == 0) checkOutput("unexpected_done", 1, 0);
            else                   checkOutput("done_cycle", cyc, doneQ.pop_front());
        end
        if (rdValid) begin
            checkOutput(rdNameQ.pop_front(), mfc0_rdata, rdExpQ.pop_front());
        end
    end

    always @(negedge resetn) begin
        #1;
        checkOutput("we_after_reset", we, 0);
        checkOutput("done_after_reset", op_done, 0);
        checkOutput("ready_after_reset", op_ready, 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0Write(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we    = 1'b1;
        mtc0_addr  = addr;
        mtc0_wdata = data;
        tick();
        mtc0_we    = 1'b0;
    endtask

    task automatic readReg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        mfc0_addr = addr;
        rdExpQ.push_back(exp);
        rdNameQ.push_back(name);
        rdValid = 1'b1;
        tick();
        rdValid = 1'b0;
    endtask

    // Issues one op; holdCycles (0..2) keeps op_valid high into EXEC/DONE.
    task automatic applyStimulus(input logic [1:0] op, input int holdCycles);
        int n = 0;
        while (!op_ready && n < 10) begin
            tick();
            n++;
        end
        if (!op_ready) checkOutput("op_ready_timeout", 0, 1);
        doneQ.push_back(cyc + 2);
        op_valid = 1'b1;
        op_type  = op;
        tick();
        repeat (holdCycles) tick();
        op_valid = 1'b0;
        repeat (2 - holdCycles) tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op_type = 2'd0; mtc0_we = 1'b0;
        mtc0_addr = '0; mtc0_wdata = '0; mfc0_addr = '0; rdValid = 1'b0;
        hitEn = 1'b0; hitVpn2 = '0; hitAsid = '0; hitIdx = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        $display("[TB] Random countdown and wrap");
        for (int i = 0; i < 18; i++) begin
            if (i == 3) begin
                mtc0_we = 1'b1; mtc0_addr = 5'd1; mtc0_wdata = 32'h0;
            end
            readReg("random", 5'd1, 32'((15 - i) & 15));
            mtc0_we = 1'b0;
        end

        readReg("index_rst", 5'd0, 32'h0);
        readReg("lo0_rst", 5'd2, 32'h0);
        readReg("lo1_rst", 5'd3, 32'h0);
        readReg("hi_rst", 5'd10, 32'h0);
        mtc0Write(5'd5, 32'hFFFF_FFFF);
        readReg("unlisted", 5'd5, 32'h0);

        $display("[TB] TLBWI");
        mtc0Write(5'd0, 32'hFFFF_FFF5);
        mtc0Write(5'd10, 32'h0040_2033);
        mtc0Write(5'd2, 32'h0000_1057);
        mtc0Write(5'd3, 32'h0000_1086);
        readReg("index_wr", 5'd0, 32'h0000_0005);
        readReg("hi_wr", 5'd10, 32'h0040_2033);
        readReg("lo0_wr", 5'd2, 32'h0000_1057);
        readReg("lo1_wr", 5'd3, 32'h0000_1086);
        expWrQ.push_back(mkWr(4'd5, 19'h00201, 8'h33, 1'b0, 20'h41, 3'd2, 1'b1, 1'b1,
                              20'h42, 3'd0, 1'b1, 1'b1));
        applyStimulus(2'd2, 0);

        $display("[TB] TLBP hit and miss");
        hitEn = 1'b1; hitVpn2 = 19'h00201; hitAsid = 8'h33; hitIdx = 4'd5;
        mtc0Write(5'd0, 32'h2);
        applyStimulus(2'd0, 0);
        readReg("tlbp_hit", 5'd0, 32'h0000_0005);
        mtc0Write(5'd10, 32'h0040_2034);
        applyStimulus(2'd0, 0);
        readReg("tlbp_miss", 5'd0, 32'h8000_0005);

        $display("[TB] TLBR");
        mtc0Write(5'd0, 32'h7);
        readReg("index_p_kept", 5'd0, 32'h8000_0007);
        applyStimulus(2'd1, 0);
        readReg("tlbr_hi", 5'd10, 32'h2468_A05A);
        readReg("tlbr_lo0", 5'd2, 32'h02AF_379D);
        readReg("tlbr_lo1", 5'd3, 32'h004D_5E6B);

        $display("[TB] TLBWR");
        expWrQ.push_back(mkWr(shadowRand - 4'd1, 19'h12345, 8'h5a, 1'b1, 20'hABCDE, 3'd3,
                              1'b1, 1'b0, 20'h13579, 3'd5, 1'b0, 1'b1));
        applyStimulus(2'd3, 0);

        $display("[TB] mtc0 Index during TLBP EXEC");
        hitVpn2 = 19'h12345; hitAsid = 8'h5a; hitIdx = 4'd9;
        doneQ.push_back(cyc + 2);
        op_valid = 1'b1; op_type = 2'd0;
        tick();
        op_valid = 1'b0;
        mtc0_we = 1'b1; mtc0_addr = 5'd0; mtc0_wdata = 32'h3;
        tick();
        mtc0_we = 1'b0;
        tick();
        readReg("tlbp_conflict", 5'd0, 32'h0000_0009);

        $display("[TB] op_valid held through EXEC/DONE");
        expWrQ.push_back(mkWr(4'd9, 19'h12345, 8'h5a, 1'b1, 20'hABCDE, 3'd3,
                              1'b1, 1'b0, 20'h13579, 3'd5, 1'b0, 1'b1));
        applyStimulus(2'd2, 2);
        repeat (3) tick();

        $display("[TB] reset during EXEC");
        op_valid = 1'b1; op_type = 2'd2;
        tick();
        op_valid = 1'b0;
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (3) tick();
        readReg("index_abort", 5'd0, 32'h0);
        readReg("hi_abort", 5'd10, 32'h0);
        readReg("lo0_abort", 5'd2, 32'h0);
        readReg("lo1_abort", 5'd3, 32'h0);

        repeat (4) tick();
        checkOutput("pending_writes", expWrQ.size(), 0);
        checkOutput("pending_done", doneQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
